// File: rtl/conv_window_mac.sv
// conv_window_mac: KxK signed-kernel MAC on the window_buffer stream, with round/shift, ReLU and saturation.
// Latency: valid_o is high in the cycle after the third edge following the edge that accepted the pixel.
// Backpressure: none; one window per cycle, back-to-back enable_i gives back-to-back valid_o.
//
// Ports:
//   clk_i, rst_ni  clock (rising edge) and asynchronous active-low reset
//   enable_i       pixel strobe, same signal that drives window_buffer
//   window_i       flattened KxK window, tap n = row*K + col, tap K*K-1 is the newest pixel
//   weight_we_i    kernel write strobe; weight_addr_i selects the tap, weight_data_i is the signed value
//   result_o       unsigned convolution result, held between pulses
//   valid_o        one-cycle pulse marking a new result_o
module conv_window_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WINDOW_SIZE  = 3,
  parameter int LINE_LENGTH  = 4,
  parameter int LINE_COUNT   = 4,
  parameter int ACC_WIDTH    = 21,
  parameter int OUT_SHIFT    = 4,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             enable_i,
  input  logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0]    window_i,
  input  logic                                             weight_we_i,
  input  logic [$clog2(WINDOW_SIZE*WINDOW_SIZE)-1:0]       weight_addr_i,
  input  logic [WEIGHT_WIDTH-1:0]                          weight_data_i,
  output logic [OUT_WIDTH-1:0]                             result_o,
  output logic                                             valid_o
);

  localparam int TAPS   = WINDOW_SIZE * WINDOW_SIZE;
  localparam int COL_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int ROW_W  = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  // Pixel is zero-extended by one bit before the signed multiply.
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LENGTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(LINE_COUNT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WINDOW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WINDOW_SIZE - 1);

  // Half an LSB of the shifted result; collapses to zero when OUT_SHIFT is 0.
  localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'((64'd1 << OUT_SHIFT) >> 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((64'd1 << OUT_WIDTH) - 64'd1);

  logic [COL_W-1:0]               col_q;
  logic [ROW_W-1:0]               row_q;
  logic                           cap_q;
  logic                           v1_q;
  logic                           v2_q;
  logic signed [WEIGHT_WIDTH-1:0] weight_q [TAPS];
  logic signed [PROD_W-1:0]       prod_c   [TAPS];
  logic signed [PROD_W-1:0]       prod_q   [TAPS];
  logic signed [ACC_WIDTH-1:0]    sum_c;
  logic signed [ACC_WIDTH-1:0]    sum_q;
  logic signed [ACC_WIDTH:0]      sum_ext;
  logic signed [ACC_WIDTH:0]      rnd_sum;
  logic signed [ACC_WIDTH:0]      shifted;
  logic [OUT_WIDTH-1:0]           sat_c;

  // Raster position of the pixel being accepted. The capture decision uses the
  // pre-increment position, so only windows whose bottom-right pixel sits at
  // row >= K-1 and col >= K-1 are taken; these never straddle a line or frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      cap_q <= 1'b0;
    end else begin
      cap_q <= enable_i && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
      if (enable_i) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Kernel store. Stage 1 reads weight_q on the same edge a write lands, so a
  // write coincident with the multiply edge is only seen by later windows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TAPS; i++) weight_q[i] <= '0;
    end else if (weight_we_i && (32'(weight_addr_i) < TAPS)) begin
      weight_q[weight_addr_i] <= weight_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_c[i] = PROD_W'($signed({1'b0, window_i[i*DATA_WIDTH +: DATA_WIDTH]}))
                * PROD_W'(weight_q[i]);
    end
  end

  // Stage 1: per-tap products.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
    end else begin
      v1_q <= cap_q;
      if (cap_q) begin
        for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_c[i];
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++) sum_c = sum_c + ACC_WIDTH'(prod_q[i]);
  end

  // Stage 2: accumulate. ACC_WIDTH is sized so this cannot overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) sum_q <= sum_c;
    end
  end

  // One guard bit keeps the rounding add from wrapping near the accumulator limit.
  always_comb begin
    sum_ext = {sum_q[ACC_WIDTH-1], sum_q};
    rnd_sum = sum_ext + RND;
    shifted = rnd_sum >>> OUT_SHIFT;
    if (shifted[ACC_WIDTH]) begin
      sat_c = '0;
    end else if (shifted > OUT_MAX) begin
      sat_c = '1;
    end else begin
      sat_c = shifted[OUT_WIDTH-1:0];
    end
  end

  // Stage 3: ReLU/saturated output, held while no new window arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= v2_q;
      if (v2_q) result_o <= sat_c;
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: directed bench for conv_window_mac on a 4x4 frame with a 3x3 kernel.
// Latency: each expected result is checked exactly three edges after its capturing pixel.
// Backpressure: none; the bench drives the pixel stream freely, with optional idle gaps.
module tb_conv_window_mac;

  logic        clk_i;
  logic        rst_ni;
  logic        enable_i;
  logic [71:0] window_i;
  logic        weight_we_i;
  logic [3:0]  weight_addr_i;
  logic [7:0]  weight_data_i;
  logic [7:0]  result_o;
  logic        valid_o;

  conv_window_mac dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .window_i      (window_i),
    .weight_we_i   (weight_we_i),
    .weight_addr_i (weight_addr_i),
    .weight_data_i (weight_data_i),
    .result_o      (result_o),
    .valid_o       (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int         errors = 0;
  int         checks = 0;
  int         pulses = 0;
  int         img [4][4];
  // Expected capture history: index 0 = latest edge, index 3 = three edges ago.
  logic       hv [4];
  logic [7:0] hr [4];
  logic [7:0] last_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win_of(input int r, input int c);
    logic [71:0] w;
    w = '0;
    if (r >= 2 && c >= 2) begin
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          w[(rr*3+cc)*8 +: 8] = 8'(img[r-2+rr][c-2+cc]);
    end
    return w;
  endfunction

  function automatic void clear_hist();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hr[i] = 8'd0;
    end
    last_res = 8'd0;
  endfunction

  // One clock cycle: drive the inputs for this edge, then after the edge
  // present the window of the accepted pixel and check the outputs.
  task automatic cyc(input logic en, input logic [71:0] win, input logic ecap,
                     input logic [7:0] eres, input logic wwe,
                     input logic [3:0] wa, input logic [7:0] wd);
    logic [7:0] exp_res;
    enable_i      = en;
    weight_we_i   = wwe;
    weight_addr_i = wa;
    weight_data_i = wd;
    @(posedge clk_i);
    #1;
    enable_i    = 1'b0;
    weight_we_i = 1'b0;
    window_i    = win;
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      hr[i] = hr[i-1];
    end
    hv[0] = ecap;
    hr[0] = eres;
    chk("valid_o", 32'(valid_o), 32'(hv[3]));
    exp_res = hv[3] ? hr[3] : last_res;
    chk("result_o", 32'(result_o), 32'(exp_res));
    last_res = exp_res;
    if (valid_o === 1'b1) pulses++;
  endtask

  task automatic gap();
    cyc(1'b0, window_i, 1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic load_w(input logic [3:0] addr, input logic [7:0] val);
    cyc(1'b0, window_i, 1'b0, 8'd0, 1'b1, addr, val);
  endtask

  task automatic load_all(input logic [7:0] val);
    for (int i = 0; i < 9; i++) load_w(4'(i), val);
  endtask

  // Stream one full 4x4 frame; e0..e3 are the hand-computed results for the
  // windows ending at pixels (2,2),(2,3),(3,2),(3,3).
  task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input bit gaps, input int wr_idx, input logic [7:0] wr_val);
    logic [7:0] er [4];
    int         p0;
    int         r;
    int         c;
    logic       cap;
    er[0] = e0; er[1] = e1; er[2] = e2; er[3] = e3;
    p0 = pulses;
    for (int idx = 0; idx < 16; idx++) begin
      r = idx / 4;
      c = idx % 4;
      if (gaps) repeat ($urandom_range(0, 2)) gap();
      cap = (r >= 2) && (c >= 2);
      cyc(1'b1, win_of(r, c), cap, cap ? er[(r-2)*2 + (c-2)] : 8'd0,
          idx == wr_idx, 4'd4, wr_val);
    end
    repeat (3) gap();
    chk("pulse_count", 32'(pulses - p0), 32'd4);
  endtask

  task automatic ramp_img();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = r*4 + c + 1;
  endtask

  task automatic fill_img(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    enable_i      = 1'b0;
    window_i      = '0;
    weight_we_i   = 1'b0;
    weight_addr_i = '0;
    weight_data_i = '0;
    clear_hist();

    // Reset held with enable toggling: outputs stay at zero.
    #2;
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'(i % 2), '0, 1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
    rst_ni = 1'b1;
    gap();

    // No kernel loaded: every window yields 0.
    ramp_img();
    run_frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, -1, 8'd0);

    // Identity (centre weight 16, >>4); out-of-range addresses must not land.
    load_w(4'd4, 8'd16);
    load_w(4'd12, 8'd100);
    load_w(4'd13, 8'd100);
    run_frame(8'd6, 8'd7, 8'd10, 8'd11, 1'b0, -1, 8'd0);

    // ReLU: all weights -1 on a white frame.
    load_all(8'hFF);
    fill_img(255);
    run_frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, -1, 8'd0);

    // Saturation: 9*255*127 = 291465 -> far above 255.
    load_all(8'h7F);
    run_frame(8'd255, 8'd255, 8'd255, 8'd255, 1'b0, -1, 8'd0);

    // Rounding: centre 8 -> (8+8)>>4 = 1, centre 7 -> (7+8)>>4 = 0.
    load_all(8'd0);
    load_w(4'd4, 8'd1);
    fill_img(0);
    img[1][1] = 8; img[1][2] = 7; img[2][1] = 8; img[2][2] = 7;
    run_frame(8'd1, 8'd0, 8'd1, 8'd0, 1'b0, -1, 8'd0);
    run_frame(8'd1, 8'd0, 8'd1, 8'd0, 1'b1, -1, 8'd0);

    // Reset mid-frame while a result is out and another sits in stage 2.
    load_w(4'd4, 8'd16);
    ramp_img();
    for (int idx = 0; idx < 12; idx++) begin
      cyc(1'b1, win_of(idx / 4, idx % 4), idx >= 10,
          (idx == 10) ? 8'd6 : (idx == 11) ? 8'd7 : 8'd0, 1'b0, 4'd0, 8'd0);
    end
    gap();
    gap();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    clear_hist();
    gap();
    gap();
    rst_ni = 1'b1;
    repeat (4) gap();

    // Counters restart at (0,0) and weights were cleared.
    run_frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, -1, 8'd0);

    // Weight write on the multiply edge of window (2,2): that window keeps
    // weight 16, later windows see 32 -> 6, (7*32+8)>>4=14, 20, 22.
    load_w(4'd4, 8'd16);
    run_frame(8'd6, 8'd14, 8'd20, 8'd22, 1'b0, 11, 8'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
